turn_sequencer: RTL and testbench
=================================

Name: turn_sequencer

Overview:
- Game-flow controller for tic-tac-toe; owns the single board write port.
- Alternates turns between the human player (cell code 11) and the AI move generator (cell code 10).
- Drives cellState to the AI, validates and commits moves into the 18-bit board register, and samples the win checker after each move.
- Declares game over with a winner code.

Parameters:
- AI_TIMEOUT, 15, max cycles in AI_TURN waiting for the AI before forfeit (1..255).

Ports:
- ph1  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- start  in  1  begin/restart a game; honoured only in IDLE or DONE
- player_valid  in  1  human move request
- player_addr  in  4  human move cell index 0..8
- player_ready  out  1  high while human move accepted
- ai_write_n  in  1  AI move ready, active-low (0 = ai_addr valid)
- ai_addr  in  4  AI move cell index; 4'hF = no move
- gBoard  in  18  current board; cell n = gBoard[2n+1:2n]
- gameResult  in  2  from win checker: 11 p1, 10 p2, 01 tie, 00 none
- cellState  out  2  turn indicator: 11 player turn, 10 AI turn, 00 otherwise
- board_we  out  1  board write strobe
- board_addr  out  4  board write cell index
- board_data  out  2  board write value
- board_clear  out  1  one-cycle pulse to clear board
- move_reject  out  1  one-cycle pulse: human move illegal
- game_over  out  1  high in DONE
- winner  out  2  latched result, valid when game_over
- ai_fault  out  1  sticky: AI timed out or gave illegal move

Behaviour:
- Reset (async, reset=0):
  - State = IDLE.
  - All outputs 0; timer 0; latched addr 0.
- Outputs are registered (Moore); all state updates on rising ph1.
- Cell n is occupied iff gBoard[2n+1]=1. Legal addr: 0..8 and unoccupied.
- IDLE: start=1 → P1_TURN; board_clear=1 for that one cycle.
- P1_TURN:
  - cellState=11, player_ready=1.
  - player_valid=1 with legal addr → latch addr, go to P1_WRITE.
  - player_valid=1 with illegal addr → move_reject=1 for one cycle, stay.
- P1_WRITE: board_we=1, board_addr=latched, board_data=11 for exactly one cycle → P1_CHECK.
- P1_CHECK: one settle cycle; sample gameResult.
  - gameResult≠00 → DONE, winner=gameResult.
  - gameResult=00 → AI_TURN, timer cleared.
- AI_TURN: cellState=10; timer increments each cycle.
  - ai_write_n=0 and ai_addr legal → latch ai_addr, go to AI_WRITE.
  - ai_write_n=0 and ai_addr illegal (including 4'hF) → ai_fault=1, winner=11, go to DONE.
  - timer reaches AI_TIMEOUT with no ready → ai_fault=1, winner=11, go to DONE.
  - A ready on the timeout cycle takes priority over the timeout.
- AI_WRITE: board_we=1, board_data=10, one cycle → AI_CHECK.
- AI_CHECK: same as P1_CHECK, except gameResult=00 → P1_TURN.
- DONE:
  - game_over=1, winner held.
  - start=1 → P1_TURN with board_clear pulse; clears ai_fault, winner, timer.
- Ignored inputs (no reject, no state change):
  - start outside IDLE/DONE.
  - player_valid outside P1_TURN.
  - ai_write_n outside AI_TURN.
- board_we never asserted outside P1_WRITE/AI_WRITE. board_addr/board_data are 0 when board_we=0.
- Timer width: $clog2(AI_TIMEOUT+1); it never wraps.
- Reset mid-write: board_we drops immediately (asynchronously).
- Illegal state encoding → IDLE next cycle.

Optional Feature:
- Macro: TURN_SEQ_MOVE_COUNT_EN.
- Defined:
  - Adds output move_count [3:0], cleared on board_clear and incremented on each board_we.
  - In P1_CHECK/AI_CHECK, move_count=9 with gameResult=00 forces DONE, winner=01 (tie), independent of the win checker.
- Undefined: no move_count port; tie detection relies solely on gameResult=01.

Test Plan:
- Reset low mid-P1_WRITE → board_we=0 immediately; after release state IDLE, all outputs 0.
- start; player addr 4 into empty board → board_clear pulse, then board_we=1, addr=4, data=11 for one cycle; cellState=10 two cycles later.
- Player addr 4 when gBoard[9]=1, then addr 9 → move_reject pulse each time, state stays P1_TURN, no board_we.
- AI_TURN, ai_write_n held 1 for 15 cycles → ai_fault=1, game_over=1, winner=11; start → ai_fault=0, P1_TURN.
- AI returns ai_write_n=0, ai_addr=4'hF → ai_fault=1, winner=11. Separately, ai_addr=2 empty → board_we, addr=2, data=10, then cellState=11.
- Full game with gameResult driven to 10 after an AI write → DONE at AI_CHECK, winner=10. With TURN_SEQ_MOVE_COUNT_EN, a 9-move game with gameResult=00 → winner=01, move_count=9.

Source files
------------

// File: rtl/turn_sequencer.sv
// Tic-tac-toe game-flow controller: alternates human/AI turns and owns the single board write port.
// Latency: Moore outputs, registered; a legal move request produces board_we on the next rising ph1.
// Backpressure: player_ready is high only in P1_TURN; moves offered in any other state are ignored.
// Optional build macro TURN_SEQ_MOVE_COUNT_EN adds move_count and a forced tie after nine moves.
module turn_sequencer #(
  parameter int unsigned AI_TIMEOUT = 15
) (
  input  logic        ph1,
  input  logic        reset,
  input  logic        start,
  input  logic        player_valid,
  input  logic [3:0]  player_addr,
  output logic        player_ready,
  input  logic        ai_write_n,
  input  logic [3:0]  ai_addr,
  input  logic [17:0] gBoard,
  input  logic [1:0]  gameResult,
  output logic [1:0]  cellState,
  output logic        board_we,
  output logic [3:0]  board_addr,
  output logic [1:0]  board_data,
  output logic        board_clear,
  output logic        move_reject,
  output logic        game_over,
  output logic [1:0]  winner,
  output logic        ai_fault
`ifdef TURN_SEQ_MOVE_COUNT_EN
  ,
  output logic [3:0]  move_count
`endif
);

  localparam int TW = (AI_TIMEOUT < 1) ? 1 : $clog2(AI_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(AI_TIMEOUT - 1);
  localparam logic [TW-1:0] TIMER_MAX  = TW'(AI_TIMEOUT);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    P1_TURN  = 3'd1,
    P1_WRITE = 3'd2,
    P1_CHECK = 3'd3,
    AI_TURN  = 3'd4,
    AI_WRITE = 3'd5,
    AI_CHECK = 3'd6,
    DONE     = 3'd7
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    winner_q, winner_d;
  logic          ai_fault_q, ai_fault_d;
  logic          clear_q, clear_d;
  logic          reject_q, reject_d;
  logic          we_q, we_d;
  logic [3:0]    baddr_q, baddr_d;
  logic [1:0]    bdata_q, bdata_d;
  logic [1:0]    cell_q, cell_d;
  logic          ready_q, ready_d;
  logic          over_q, over_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          nine_moves;

  // Only the high bit of each cell marks occupancy; the owner bit is irrelevant here.
  logic [15:0] occ;
  logic        board_lo_unused;

  // Gather the occupancy bit of every cell, zero-padded so any 4-bit index is safe.
  always_comb begin
    occ = '0;
    for (int i = 0; i < 9; i++) begin
      occ[i] = gBoard[2*i+1];
    end
  end

  assign board_lo_unused = ^{gBoard[16], gBoard[14], gBoard[12], gBoard[10], gBoard[8],
                             gBoard[6], gBoard[4], gBoard[2], gBoard[0]};

  function automatic logic is_legal(input logic [3:0] a, input logic [15:0] o);
    return (a < 4'd9) && !o[a];
  endfunction

`ifdef TURN_SEQ_MOVE_COUNT_EN
  assign nine_moves = (cnt_q == 4'd9);
  assign move_count = cnt_q;
`else
  assign nine_moves = 1'b0;
`endif

  // Next-state, latched move address, AI timer and result bookkeeping.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    timer_d    = timer_q;
    winner_d   = winner_q;
    ai_fault_d = ai_fault_q;
    clear_d    = 1'b0;
    reject_d   = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = P1_TURN;
          clear_d    = 1'b1;
          winner_d   = 2'b00;
          ai_fault_d = 1'b0;
          timer_d    = '0;
        end
      end
      P1_TURN: begin
        if (player_valid) begin
          if (is_legal(player_addr, occ)) begin
            addr_d  = player_addr;
            state_d = P1_WRITE;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      P1_WRITE: state_d = P1_CHECK;
      AI_WRITE: state_d = AI_CHECK;
      P1_CHECK, AI_CHECK: begin
        if (gameResult != 2'b00) begin
          state_d  = DONE;
          winner_d = gameResult;
        end else if (nine_moves) begin
          state_d  = DONE;
          winner_d = 2'b01;
        end else if (state_q == P1_CHECK) begin
          state_d = AI_TURN;
          timer_d = '0;
        end else begin
          state_d = P1_TURN;
        end
      end
      AI_TURN: begin
        if (timer_q != TIMER_MAX) begin
          timer_d = timer_q + 1'b1;
        end
        // A ready AI move wins over a timeout landing in the same cycle.
        if (!ai_write_n) begin
          if (is_legal(ai_addr, occ)) begin
            addr_d  = ai_addr;
            state_d = AI_WRITE;
          end else begin
            state_d    = DONE;
            ai_fault_d = 1'b1;
            winner_d   = 2'b11;
          end
        end else if (timer_q >= TIMER_LAST) begin
          state_d    = DONE;
          ai_fault_d = 1'b1;
          winner_d   = 2'b11;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs decoded from the upcoming state so they register alongside it.
  always_comb begin
    we_d    = (state_d == P1_WRITE) || (state_d == AI_WRITE);
    baddr_d = we_d ? addr_d : 4'd0;
    bdata_d = (state_d == P1_WRITE) ? 2'b11 : ((state_d == AI_WRITE) ? 2'b10 : 2'b00);
    cell_d  = (state_d == P1_TURN) ? 2'b11 : ((state_d == AI_TURN) ? 2'b10 : 2'b00);
    ready_d = (state_d == P1_TURN);
    over_d  = (state_d == DONE);
    cnt_d   = cnt_q;
    if (clear_d) begin
      cnt_d = 4'd0;
    end else if (we_q && (cnt_q != 4'hF)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // State and output registers; reset clears everything, dropping board_we at once.
  always_ff @(posedge ph1 or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= 4'd0;
      timer_q    <= '0;
      winner_q   <= 2'b00;
      ai_fault_q <= 1'b0;
      clear_q    <= 1'b0;
      reject_q   <= 1'b0;
      we_q       <= 1'b0;
      baddr_q    <= 4'd0;
      bdata_q    <= 2'b00;
      cell_q     <= 2'b00;
      ready_q    <= 1'b0;
      over_q     <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      timer_q    <= timer_d;
      winner_q   <= winner_d;
      ai_fault_q <= ai_fault_d;
      clear_q    <= clear_d;
      reject_q   <= reject_d;
      we_q       <= we_d;
      baddr_q    <= baddr_d;
      bdata_q    <= bdata_d;
      cell_q     <= cell_d;
      ready_q    <= ready_d;
      over_q     <= over_d;
      cnt_q      <= cnt_d;
    end
  end

  assign player_ready = ready_q;
  assign cellState    = cell_q;
  assign board_we     = we_q;
  assign board_addr   = baddr_q;
  assign board_data   = bdata_q;
  assign board_clear  = clear_q;
  assign move_reject  = reject_q;
  assign game_over    = over_q;
  assign winner       = winner_q;
  assign ai_fault     = ai_fault_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: a board model plus a queue of expected writes.
// Expected writes are queued as moves are offered and checked when board_we appears.
module tb_turn_sequencer;

  logic        ph1 = 1'b0;
  logic        reset;
  logic        start;
  logic        player_valid;
  logic [3:0]  player_addr;
  logic        player_ready;
  logic        ai_write_n;
  logic [3:0]  ai_addr;
  logic [17:0] g_board;
  logic [1:0]  game_result;
  logic [1:0]  cell_state;
  logic        board_we;
  logic [3:0]  board_addr;
  logic [1:0]  board_data;
  logic        board_clear;
  logic        move_reject;
  logic        game_over;
  logic [1:0]  winner;
  logic        ai_fault;
`ifdef TURN_SEQ_MOVE_COUNT_EN
  logic [3:0]  move_count;
`endif

  typedef struct {
    logic [3:0] addr;
    logic [1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_total = 0;
  int  n_pass  = 0;

  always #5 ph1 = ~ph1;

  turn_sequencer #(.AI_TIMEOUT(15)) dut (
    .ph1          (ph1),
    .reset        (reset),
    .start        (start),
    .player_valid (player_valid),
    .player_addr  (player_addr),
    .player_ready (player_ready),
    .ai_write_n   (ai_write_n),
    .ai_addr      (ai_addr),
    .gBoard       (g_board),
    .gameResult   (game_result),
    .cellState    (cell_state),
    .board_we     (board_we),
    .board_addr   (board_addr),
    .board_data   (board_data),
    .board_clear  (board_clear),
    .move_reject  (move_reject),
    .game_over    (game_over),
    .winner       (winner),
    .ai_fault     (ai_fault)
`ifdef TURN_SEQ_MOVE_COUNT_EN
    ,
    .move_count   (move_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // One clock; sample after the edge, retire expected writes and update the board model.
  task automatic step();
    wr_t e;
    @(posedge ph1);
    #1;
    if (board_clear) g_board = '0;
    if (board_we) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_we", board_we, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("we_addr", board_addr, e.addr);
        chk("we_data", board_data, e.data);
      end
      if (board_addr < 4'd9) g_board[2*board_addr +: 2] = board_data;
    end
  endtask

  task automatic p1_move(input logic [3:0] a);
    player_valid = 1'b1;
    player_addr  = a;
    exp_q.push_back('{addr: a, data: 2'b11});
    step();
    player_valid = 1'b0;
    step();
    step();
  endtask

  task automatic ai_move(input logic [3:0] a);
    ai_write_n = 1'b0;
    ai_addr    = a;
    exp_q.push_back('{addr: a, data: 2'b10});
    step();
    ai_write_n = 1'b1;
    step();
    step();
  endtask

  task automatic new_game();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0; start = 1'b0; player_valid = 1'b0; player_addr = 4'd0;
    ai_write_n = 1'b1; ai_addr = 4'd0; g_board = '0; game_result = 2'b00;
    step();
    step();
    chk("rst_cell", cell_state, 2'b00);
    chk("rst_ready", player_ready, 1'b0);
    chk("rst_over", game_over, 1'b0);
    chk("rst_winner", winner, 2'b00);
    chk("rst_fault", ai_fault, 1'b0);
    reset = 1'b1;
    step();
    chk("idle_cell", cell_state, 2'b00);

    // Game 1: player 4, AI 2, illegal player attempts, then AI wins.
    new_game();
    chk("g1_clear", board_clear, 1'b1);
    chk("g1_p1_cell", cell_state, 2'b11);
    chk("g1_p1_ready", player_ready, 1'b1);
    player_valid = 1'b1; player_addr = 4'd4;
    exp_q.push_back('{addr: 4'd4, data: 2'b11});
    step();
    chk("g1_we_seen", exp_q.size(), 0);
    chk("g1_clear_once", board_clear, 1'b0);
    player_valid = 1'b0;
    step();
    chk("g1_check_we", board_we, 1'b0);
    step();
    chk("g1_ai_cell", cell_state, 2'b10);
    ai_move(4'd2);
    chk("g1_back_p1", cell_state, 2'b11);
    player_valid = 1'b1; player_addr = 4'd4;
    step();
    chk("rej_occupied", move_reject, 1'b1);
    chk("rej_stay", player_ready, 1'b1);
    player_addr = 4'd9;
    step();
    chk("rej_range", move_reject, 1'b1);
    player_addr = 4'd2;
    step();
    chk("rej_ai_cell", move_reject, 1'b1);
    player_valid = 1'b0;
    step();
    chk("rej_pulse_end", move_reject, 1'b0);
    p1_move(4'd0);
    ai_write_n = 1'b0; ai_addr = 4'd8;
    exp_q.push_back('{addr: 4'd8, data: 2'b10});
    step();
    ai_write_n = 1'b1;
    game_result = 2'b10;
    step();
    step();
    game_result = 2'b00;
    chk("ai_win_over", game_over, 1'b1);
    chk("ai_win_winner", winner, 2'b10);
    chk("ai_win_fault", ai_fault, 1'b0);
    player_valid = 1'b1; player_addr = 4'd5;
    step();
    player_valid = 1'b0;
    chk("done_ignore_player", game_over, 1'b1);
    chk("done_no_reject", move_reject, 1'b0);

    // Game 2: AI never answers and forfeits on its fifteenth cycle.
    new_game();
    chk("g2_winner_clr", winner, 2'b00);
    p1_move(4'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_ignored", board_clear, 1'b0);
    repeat (13) step();
    chk("to_still_ai", cell_state, 2'b10);
    chk("to_no_fault_yet", ai_fault, 1'b0);
    step();
    chk("to_fault", ai_fault, 1'b1);
    chk("to_over", game_over, 1'b1);
    chk("to_winner", winner, 2'b11);
    new_game();
    chk("restart_fault_clr", ai_fault, 1'b0);
    chk("restart_cell", cell_state, 2'b11);
    chk("restart_over", game_over, 1'b0);

    // Game 2 continued: a ready on the timeout cycle beats the timeout.
    p1_move(4'd5);
    repeat (14) step();
    ai_write_n = 1'b0; ai_addr = 4'd6;
    exp_q.push_back('{addr: 4'd6, data: 2'b10});
    step();
    ai_write_n = 1'b1;
    chk("edge_no_fault", ai_fault, 1'b0);
    chk("edge_not_over", game_over, 1'b0);
    step();
    step();
    chk("edge_back_p1", cell_state, 2'b11);

    // AI names no cell at all.
    p1_move(4'd7);
    ai_write_n = 1'b0; ai_addr = 4'hF;
    step();
    ai_write_n = 1'b1;
    chk("bad_ai_fault", ai_fault, 1'b1);
    chk("bad_ai_winner", winner, 2'b11);
    chk("bad_ai_over", game_over, 1'b1);

    // Game 3: win checker reports a tie right after the player move.
    new_game();
    game_result = 2'b01;
    p1_move(4'd3);
    game_result = 2'b00;
    chk("tie_winner", winner, 2'b01);
    chk("tie_cell", cell_state, 2'b00);

    // Reset asserted while the board write is on the bus.
    new_game();
    player_valid = 1'b1; player_addr = 4'd6;
    @(posedge ph1);
    #1;
    player_valid = 1'b0;
    chk("mid_we_on", board_we, 1'b1);
    chk("mid_we_addr", board_addr, 4'd6);
    #2 reset = 1'b0;
    #1;
    chk("mid_we_async", board_we, 1'b0);
    chk("mid_addr_zero", board_addr, 4'd0);
    step();
    reset = 1'b1;
    g_board = '0;
    step();
    chk("post_rst_cell", cell_state, 2'b00);
    chk("post_rst_ready", player_ready, 1'b0);
    chk("post_rst_we", board_we, 1'b0);

`ifdef TURN_SEQ_MOVE_COUNT_EN
    // Nine moves with no verdict from the win checker end as a tie.
    new_game();
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) p1_move(4'(i));
      else ai_move(4'(i));
    end
    chk("mc_over", game_over, 1'b1);
    chk("mc_winner", winner, 2'b01);
    chk("mc_count", move_count, 4'd9);
`endif

    chk("exp_q_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
